voice_mixer: RTL and testbench
==============================

Name: voice_mixer

Overview:
- Downstream of the per-voice oscillators.
- Captures all voice outputs on each sample tick and sums the enabled ones sequentially, one voice per clk.
- Applies a master gain, removes the fixed-point fraction, saturates to the output sample width, and presents the result on a valid/ready handshake to the DAC/serializer stage.

Parameters:
- N_VOICES, 8, number of oscillator voices mixed (power of two, >=2).
- IN_WIDTH, 32, width of each signed voice sample (integer + fraction bits).
- FRAC_BITS, 8, fractional bits in each voice sample.
- OUT_WIDTH, 24, width of signed output sample.
- GAIN_WIDTH, 16, width of unsigned master gain, Q1.15 (0x8000 = 1.0).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_tick  in  1  one-cycle strobe: a new sample period begins
- voices  in  N_VOICES x IN_WIDTH  signed oscillator outputs, index 0..N_VOICES-1
- voice_active  in  N_VOICES  per-voice enable mask; bit i gates voices[i]
- master_gain  in  GAIN_WIDTH  unsigned Q1.15 master volume
- out_sample  out  OUT_WIDTH  signed mixed sample
- out_valid  out  1  out_sample is valid
- out_ready  in  1  downstream accepts the sample
- out_clipped  out  1  saturation occurred for the current out_sample
- overrun_count  out  8  saturating count of dropped sample_ticks

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high; it is sampled on posedge clk.
- Reset state: state=IDLE, accumulator=0, index=0. Outputs: out_sample=0, out_valid=0, out_clipped=0, overrun_count=0.
- Reset mid-operation: reset abandons any mix in progress; no partial output is produced.
- States: IDLE, ACCUM, SCALE, OUTPUT.
- IDLE:
  - On sample_tick, latch voices and voice_active into shadow registers, and latch master_gain.
  - Clear the accumulator, set index=0, go to ACCUM.
- ACCUM:
  - Each cycle: acc += shadow_active[index] ? sign-extended shadow_voice[index] : 0; then index++.
  - After N_VOICES cycles (index wraps to 0), go to SCALE.
  - Accumulator width is IN_WIDTH + $clog2(N_VOICES); it never overflows.
- SCALE, single cycle:
  - p = acc * gain, signed x unsigned, full precision.
  - r = p >>> (15 + FRAC_BITS), arithmetic shift (floor).
  - If r > 2^(OUT_WIDTH-1)-1, output that maximum with out_clipped=1.
  - If r < -2^(OUT_WIDTH-1), output that minimum with out_clipped=1.
  - Otherwise output r with out_clipped=0.
  - Register out_sample and out_clipped, set out_valid=1, go to OUTPUT.
- OUTPUT:
  - out_sample, out_clipped and out_valid are held stable until out_valid && out_ready.
  - On that handshake: clear out_valid next cycle and go to IDLE.
- Latency: with out_ready=1, sample_tick at cycle T gives out_valid=1 at T+N_VOICES+2; the handshake occurs in the same cycle.
- Tick acceptance:
  - A sample_tick is accepted when state=IDLE.
  - It is also accepted when state=OUTPUT and the handshake completes in the same cycle; capture then happens immediately and the next state is ACCUM.
  - Any other sample_tick is dropped and overrun_count increments, saturating at 255.
  - Shadow registers are unaffected by a dropped tick.
- Input stability: voices, voice_active and master_gain changing during ACCUM/SCALE do not affect the mix in progress.
- voice_active=0: the full sequence still runs, out_sample=0.

Optional Feature:
- Macro: VOICE_MIXER_AUTO_ATTEN_EN.
- Defined: in SCALE the shift becomes 15 + FRAC_BITS + $clog2(N_VOICES), i.e. fixed headroom of 1/N_VOICES so that a full-scale sum of all voices cannot clip. All timing is unchanged.
- Undefined: shift is 15 + FRAC_BITS as specified above.

Test Plan:
1. Assert reset 3 cycles mid-ACCUM -> next cycle out_valid=0, out_sample=0, out_clipped=0, overrun_count=0, state IDLE; no output appears.
2. All 8 voices = 256000 (1000.0), voice_active=0xFF, master_gain=0x8000, out_ready=1, tick at T -> out_valid at T+10, out_sample=8000, out_clipped=0; out_valid low at T+11.
3. Saturation:
   - All voices = 0x7FFFFFFF, mask 0xFF, gain 0x8000 -> out_sample=0x7FFFFF, out_clipped=1.
   - All voices = 0x80000000 -> out_sample=0x800000, out_clipped=1.
4. Mask and gain: voice0 = -128000 (-500.0), voices1..7 = 3160320, voice_active=0x01, gain=0x4000 -> out_sample=-250.
5. Backpressure and overrun:
   - Run scenario 2 with out_ready=0; second tick at T+12 -> overrun_count=1, out_sample stays 8000.
   - Raise out_ready at T+20 -> handshake that cycle, out_valid=0 at T+21.
   - Tick coincident with a handshake is accepted with no overrun increment.
6. With VOICE_MIXER_AUTO_ATTEN_EN defined, scenario 2 -> out_sample=1000; scenario 3 positive case -> out_sample=0x7FFFFF, out_clipped=0.

Source files
------------

// File: rtl/voice_mixer.sv
// Sequential voice mixer: capture on tick, sum one voice per clk, gain, saturate, handshake out.
// Optional VOICE_MIXER_AUTO_ATTEN_EN adds a fixed 1/N_VOICES headroom shift in SCALE.
module voice_mixer #(
    parameter int N_VOICES   = 8,
    parameter int IN_WIDTH   = 32,
    parameter int FRAC_BITS  = 8,
    parameter int OUT_WIDTH  = 24,
    parameter int GAIN_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                sample_tick,
    input  logic [N_VOICES-1:0][IN_WIDTH-1:0]   voices,
    input  logic [N_VOICES-1:0]                 voice_active,
    input  logic [GAIN_WIDTH-1:0]               master_gain,
    output logic [OUT_WIDTH-1:0]                out_sample,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_clipped,
    output logic [7:0]                          overrun_count
);

    localparam int IDX_W  = $clog2(N_VOICES);
    localparam int ACC_W  = IN_WIDTH + IDX_W;
    localparam int PROD_W = ACC_W + GAIN_WIDTH + 1;
`ifdef VOICE_MIXER_AUTO_ATTEN_EN
    localparam int SHIFT  = 15 + FRAC_BITS + IDX_W;
`else
    localparam int SHIFT  = 15 + FRAC_BITS;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_SCALE  = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    logic [1:0]                         r_state;
    logic [N_VOICES-1:0][IN_WIDTH-1:0]  r_voices;
    logic [N_VOICES-1:0]                r_active;
    logic [GAIN_WIDTH-1:0]              r_gain;
    logic signed [ACC_W-1:0]            r_acc;
    logic [IDX_W-1:0]                   r_idx;
    logic [OUT_WIDTH-1:0]               r_out;
    logic                               r_valid;
    logic                               r_clip;
    logic [7:0]                         r_overrun;

    logic                               w_hs;
    logic                               w_accept;
    logic [IN_WIDTH-1:0]                w_voice;
    logic signed [ACC_W-1:0]            w_term;
    logic signed [PROD_W-1:0]           w_prod;
    logic signed [PROD_W-1:0]           w_shift;
    logic signed [PROD_W-1:0]           w_max;
    logic signed [PROD_W-1:0]           w_min;
    logic [OUT_WIDTH-1:0]               w_sat;
    logic                               w_sat_clip;

    assign w_hs     = (r_state == S_OUTPUT) && r_valid && out_ready;
    assign w_accept = sample_tick && ((r_state == S_IDLE) || w_hs);

    assign w_voice = r_voices[r_idx];
    assign w_term  = r_active[r_idx]
                   ? {{IDX_W{w_voice[IN_WIDTH-1]}}, w_voice}
                   : '0;

    // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
    assign w_prod  = r_acc * $signed({1'b0, r_gain});
    assign w_shift = w_prod >>> SHIFT;
    assign w_max   = {{(PROD_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    assign w_min   = {{(PROD_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    always_comb begin
        w_sat      = w_shift[OUT_WIDTH-1:0];
        w_sat_clip = 1'b0;
        if (w_shift > w_max) begin
            w_sat      = w_max[OUT_WIDTH-1:0];
            w_sat_clip = 1'b1;
        end else if (w_shift < w_min) begin
            w_sat      = w_min[OUT_WIDTH-1:0];
            w_sat_clip = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_voices  <= '0;
            r_active  <= '0;
            r_gain    <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_clip    <= 1'b0;
            r_overrun <= '0;
        end else begin
            if (sample_tick && !w_accept && (r_overrun != 8'hFF))
                r_overrun <= r_overrun + 8'd1;

            if (w_accept) begin
                r_voices <= voices;
                r_active <= voice_active;
                r_gain   <= master_gain;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (sample_tick) begin
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX)
                        r_state <= S_SCALE;
                end
                S_SCALE: begin
                    r_out   <= w_sat;
                    r_clip  <= w_sat_clip;
                    r_valid <= 1'b1;
                    r_state <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        if (sample_tick) begin
                            r_acc   <= '0;
                            r_idx   <= '0;
                            r_state <= S_ACCUM;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_sample    = r_out;
    assign out_valid     = r_valid;
    assign out_clipped   = r_clip;
    assign overrun_count = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed self-checking bench for voice_mixer (default 8 voices, Q.8 samples, Q1.15 gain).
module tb_voice_mixer;

    logic              clk;
    logic              reset;
    logic              sample_tick;
    logic [7:0][31:0]  voices;
    logic [7:0]        voice_active;
    logic [15:0]       master_gain;
    logic [23:0]       out_sample;
    logic              out_valid;
    logic              out_ready;
    logic              out_clipped;
    logic [7:0]        overrun_count;

    int checks = 0;
    int errors = 0;

`ifdef VOICE_MIXER_AUTO_ATTEN_EN
    localparam logic [23:0] EXP_8000  = 24'd1000;
    localparam logic [23:0] EXP_4000  = 24'd500;
    localparam logic [23:0] EXP_M250  = -24'sd32;
    localparam logic        EXP_CLIP  = 1'b0;
`else
    localparam logic [23:0] EXP_8000  = 24'd8000;
    localparam logic [23:0] EXP_4000  = 24'd4000;
    localparam logic [23:0] EXP_M250  = -24'sd250;
    localparam logic        EXP_CLIP  = 1'b1;
`endif

    voice_mixer dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .voices        (voices),
        .voice_active  (voice_active),
        .master_gain   (master_gain),
        .out_sample    (out_sample),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_clipped   (out_clipped),
        .overrun_count (overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < 8; i++) voices[i] = v;
    endtask

    // Tick now, scramble inputs mid-mix, then check latency and the result.
    task automatic mix(input string tag, input logic [23:0] exp_s,
                       input logic exp_c);
        logic [7:0] act;
        act = voice_active;
        out_ready   = 1'b1;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        set_all(32'h5A5A_5A5A);
        voice_active = ~act;
        master_gain  = 16'hFFFF;
        step(8);
        chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        step();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_sample"}, {8'd0, out_sample}, {8'd0, exp_s});
        chk({tag, "_clip"}, {31'd0, out_clipped}, {31'd0, exp_c});
        step();
        chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        reset        = 1'b1;
        sample_tick  = 1'b0;
        voices       = '0;
        voice_active = '0;
        master_gain  = '0;
        out_ready    = 1'b1;
        step(2);
        reset = 1'b0;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sample", {8'd0, out_sample}, 32'd0);
        chk("rst_clip", {31'd0, out_clipped}, 32'd0);
        chk("rst_overrun", {24'd0, overrun_count}, 32'd0);

        // Reset mid-ACCUM abandons the mix
        set_all(32'd256000);
        voice_active = 8'hFF;
        master_gain  = 16'h8000;
        sample_tick  = 1'b1;
        step();
        sample_tick = 1'b0;
        step(3);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sample", {8'd0, out_sample}, 32'd0);
        chk("midrst_clip", {31'd0, out_clipped}, 32'd0);
        chk("midrst_overrun", {24'd0, overrun_count}, 32'd0);
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("midrst_noout", seen, 0);

        // Nominal full mix
        set_all(32'd256000);
        voice_active = 8'hFF;
        master_gain  = 16'h8000;
        mix("nom", EXP_8000, 1'b0);

        // Saturation
        set_all(32'h7FFF_FFFF);
        voice_active = 8'hFF;
        master_gain  = 16'h8000;
        mix("satp", 24'h7FFFFF, EXP_CLIP);
        set_all(32'h8000_0000);
        voice_active = 8'hFF;
        master_gain  = 16'h8000;
        mix("satn", 24'h800000, EXP_CLIP);

        // Mask and half gain
        set_all(32'd3160320);
        voices[0]    = -32'sd128000;
        voice_active = 8'h01;
        master_gain  = 16'h4000;
        mix("mask", EXP_M250, 1'b0);

        // Empty mask
        set_all(32'd256000);
        voice_active = 8'h00;
        master_gain  = 16'h8000;
        mix("zero", 24'd0, 1'b0);

        // Backpressure and dropped tick
        set_all(32'd256000);
        voice_active = 8'hFF;
        master_gain  = 16'h8000;
        out_ready    = 1'b0;
        sample_tick  = 1'b1;
        step();
        sample_tick = 1'b0;
        step(9);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_sample", {8'd0, out_sample}, {8'd0, EXP_8000});
        step();
        set_all(32'd128000);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk("bp_overrun", {24'd0, overrun_count}, 32'd1);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        step(6);
        chk("bp_hold_sample", {8'd0, out_sample}, {8'd0, EXP_8000});
        out_ready = 1'b1;
        step();
        chk("bp_release", {31'd0, out_valid}, 32'd0);
        chk("bp_overrun2", {24'd0, overrun_count}, 32'd1);

        // Tick coincident with handshake
        set_all(32'd128000);
        out_ready   = 1'b0;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step(9);
        chk("co_valid", {31'd0, out_valid}, 32'd1);
        chk("co_sample", {8'd0, out_sample}, {8'd0, EXP_4000});
        step(2);
        set_all(32'd256000);
        out_ready   = 1'b1;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        set_all(32'd0);
        chk("co_hs", {31'd0, out_valid}, 32'd0);
        chk("co_overrun", {24'd0, overrun_count}, 32'd1);
        step(2);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk("accum_overrun", {24'd0, overrun_count}, 32'd2);
        step(5);
        chk("co_early", {31'd0, out_valid}, 32'd0);
        step();
        chk("co2_valid", {31'd0, out_valid}, 32'd1);
        chk("co2_sample", {8'd0, out_sample}, {8'd0, EXP_8000});
        step();
        chk("co2_drop", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
